// File: rtl/bpred_update_ctrl.sv
// Purpose: queue tag-collision and outcome updates, issuing one predictor write per cycle, with a flush drain.
// Latency: an accepted request issues no earlier than the following cycle; the head issues combinationally.
// Backpressure: readys drop when a queue is full or outside RUN; a full queue refuses even while it dequeues.

// Small generic FIFO used for both request queues.
module bpred_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       wr_vld,
  input  logic [W-1:0]               wr_dat,
  input  logic                       rd_rdy,
  output logic [W-1:0]               rd_dat,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_ok;
  logic          rd_ok;

  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign wr_ok  = wr_vld && !full;
  assign rd_ok  = rd_rdy && !empty;
  assign rd_dat = mem[rd_ptr];

  // Pointers wrap naturally since DEPTH is a power of two; count tracks occupancy.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(wr_ok) - CW'(rd_ok);
    end
  end

  // Storage is write-only on accept; contents need no reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_dat;
  end
endmodule

module bpred_update_ctrl #(
  parameter int WORD_SIZE   = 16,
  parameter int QUEUE_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 tag_valid,
  input  logic [WORD_SIZE-1:0] tag_pc,
  input  logic [WORD_SIZE-1:0] tag_target,
  output logic                 tag_ready,
  input  logic                 out_valid,
  input  logic [WORD_SIZE-1:0] out_pc,
  input  logic                 out_taken,
  output logic                 out_ready,
  input  logic                 flush_req,
  output logic                 flush_done,
  output logic                 update_tag,
  output logic [WORD_SIZE-1:0] pc_collided,
  output logic [WORD_SIZE-1:0] branch_target,
  output logic                 update_bht,
  output logic [WORD_SIZE-1:0] pc_outcome,
  output logic                 branch_outcome
);
  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  state_t state;
  state_t state_nxt;
  logic   last_tag;   // 1: tag source was served last, so outcome wins a tie

  logic [2*WORD_SIZE-1:0] tag_head;
  logic [WORD_SIZE:0]     out_head;
  logic [CW-1:0]          tag_cnt;
  logic [CW-1:0]          out_cnt;
  logic [CW-1:0]          tag_cnt_nxt;
  logic [CW-1:0]          out_cnt_nxt;
  logic                   tag_full, tag_empty;
  logic                   out_full, out_empty;
  logic                   tag_push, out_push;
  logic                   issue_tag, issue_out;
  logic                   all_empty_nxt;

  assign tag_ready  = !tag_full && (state == RUN);
  assign out_ready  = !out_full && (state == RUN);
  assign flush_done = (state == DONE);
  assign tag_push   = tag_valid && tag_ready;
  assign out_push   = out_valid && out_ready;

  bpred_fifo #(.W(2*WORD_SIZE), .DEPTH(QUEUE_DEPTH)) u_tag_q (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_vld  (tag_push),
    .wr_dat  ({tag_pc, tag_target}),
    .rd_rdy  (issue_tag),
    .rd_dat  (tag_head),
    .count   (tag_cnt),
    .full    (tag_full),
    .empty   (tag_empty)
  );

  bpred_fifo #(.W(WORD_SIZE+1), .DEPTH(QUEUE_DEPTH)) u_out_q (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_vld  (out_push),
    .wr_dat  ({out_pc, out_taken}),
    .rd_rdy  (issue_out),
    .rd_dat  (out_head),
    .count   (out_cnt),
    .full    (out_full),
    .empty   (out_empty)
  );

  // Round-robin grant between queue heads; a lone non-empty queue issues every cycle.
  always_comb begin
    issue_tag = 1'b0;
    issue_out = 1'b0;
    if (!tag_empty && !out_empty) begin
      if (last_tag) issue_out = 1'b1;
      else          issue_tag = 1'b1;
    end else begin
      issue_tag = !tag_empty;
      issue_out = !out_empty;
    end
  end

  // Drive only the granted source's fields; everything else reads zero.
  always_comb begin
    update_tag     = issue_tag;
    update_bht     = issue_out;
    pc_collided    = issue_tag ? tag_head[2*WORD_SIZE-1:WORD_SIZE] : '0;
    branch_target  = issue_tag ? tag_head[WORD_SIZE-1:0] : '0;
    pc_outcome     = issue_out ? out_head[WORD_SIZE:1] : '0;
    branch_outcome = issue_out ? out_head[0] : 1'b0;
  end

  // Occupancy after this edge decides whether a drain is finished.
  assign tag_cnt_nxt   = tag_cnt + CW'(tag_push) - CW'(issue_tag);
  assign out_cnt_nxt   = out_cnt + CW'(out_push) - CW'(issue_out);
  assign all_empty_nxt = (tag_cnt_nxt == '0) && (out_cnt_nxt == '0);

  // Flush sequencing: RUN -> DRAIN (or straight to DONE if nothing remains) -> DONE -> RUN.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (flush_req) state_nxt = all_empty_nxt ? DONE : DRAIN;
      DRAIN:   if (all_empty_nxt) state_nxt = DONE;
      DONE:    state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // State register and last-grant tracking.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= RUN;
      last_tag <= 1'b1;
    end else begin
      state <= state_nxt;
      if (issue_tag || issue_out) last_tag <= issue_tag;
    end
  end
endmodule
